// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: sequencer states and access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  // Access size as carried in funct3[1:0]; 2'b11 is not a legal size.
  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

endpackage

// File: rtl/lsu_store_align.sv
// Forms byte enables and lane-replicated store data from access size and byte offset.
module lsu_store_align
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic [SIZE-1:0] wdata,
  output logic [3:0]      be,
  output logic [SIZE-1:0] wdata_rep
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (size)
      LSU_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_H: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
      end
      LSU_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, req/gnt/rvalid handshake, pipeline stall,
// raw load word hand-off to WB, and timeout-based bus error.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_op_valid,
  input  logic            mem_we,
  input  logic [2:0]      funct3,
  input  logic [SIZE-1:0] addr,
  input  logic [SIZE-1:0] wdata,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [SIZE-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [SIZE-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [SIZE-1:0] dmem_rdata,
  output logic            ld_valid,
  output logic [SIZE-1:0] ld_data,
  output logic [2:0]      ld_funct3,
  output logic [1:0]      ld_offset,
  output logic            misalign_exc,
  output logic            bus_err,
  output logic [SIZE-1:0] exc_addr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state, state_nxt;
  logic            we_q;
  logic [SIZE-1:0] addr_q;
  logic [CNT_W-1:0] cnt;

  logic            misaligned;
  logic            accept;
  logic            expired;
  logic            timeout;
  logic            rd_done;
  logic [3:0]      be_w;
  logic [SIZE-1:0] wdata_w;

  lsu_store_align #(.SIZE(SIZE)) u_store_align (
    .size      (funct3[1:0]),
    .offset    (addr[1:0]),
    .wdata     (wdata),
    .be        (be_w),
    .wdata_rep (wdata_w)
  );

  always_comb begin
    case (funct3[1:0])
      LSU_B:   misaligned = 1'b0;
      LSU_H:   misaligned = addr[0];
      LSU_W:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign accept  = (state == IDLE) && mem_op_valid && !misaligned;
  assign expired = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = we_q;
        // A load whose data arrives with the grant completes without visiting WAIT_R.
        if (dmem_gnt && (we_q || dmem_rvalid)) begin
          state_nxt = DONE;
        end else if (expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else if (dmem_gnt) begin
          state_nxt = WAIT_R;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          state_nxt = DONE;
        end else if (expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rd_done = (state_nxt == DONE) && !we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      cnt          <= '0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= '0;
      ld_valid     <= 1'b0;
      ld_data      <= '0;
      ld_funct3    <= 3'b000;
      ld_offset    <= 2'b00;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      exc_addr     <= '0;
    end else begin
      state        <= state_nxt;
      ld_valid     <= rd_done;
      misalign_exc <= 1'b0;
      bus_err      <= timeout;

      if ((state == IDLE) && mem_op_valid && misaligned) begin
        misalign_exc <= 1'b1;
        exc_addr     <= addr;
      end

      if (timeout) begin
        exc_addr <= addr_q;
      end

      if (accept) begin
        we_q       <= mem_we;
        addr_q     <= addr;
        ld_funct3  <= funct3;
        ld_offset  <= addr[1:0];
        dmem_addr  <= {addr[SIZE-1:2], 2'b00};
        dmem_be    <= be_w;
        dmem_wdata <= wdata_w;
        cnt        <= '0;
      end else if ((state == REQ) || (state == WAIT_R)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (rd_done) begin
        ld_data <= dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of the load/store rules.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        mem_op_valid;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        misalign_exc;
  logic        bus_err;
  logic [31:0] exc_addr;

  int n_tests;
  int n_fail;

  // Last accepted op's funct3/offset, which the DUT must hold until the next acceptance.
  logic [2:0] last_f3;
  logic [1:0] last_off;

  lsu_ctrl #(.SIZE(32), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_op_valid (mem_op_valid),
    .mem_we       (mem_we),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_funct3    (ld_funct3),
    .ld_offset    (ld_offset),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err),
    .exc_addr     (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int off;
    sz  = int'(f3[1:0]);
    off = int'(a[1:0]);
    if (sz == 3) return 1'b1;
    if (sz == 1) return (off % 2) != 0;
    if (sz == 2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int off;
    sz  = int'(f3[1:0]);
    off = int'(a[1:0]);
    if (sz == 0) return 4'(1 * (2 ** off));
    if (sz == 1) return 4'(3 * (2 ** off));
    return 4'hF;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return 32'(wd % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return 32'(wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // Issues one EX op and plays the memory side: gnt after g REQ cycles, rvalid rv cycles
  // after gnt (loads). Entered and left just after a rising edge.
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int g, input int rv,
                       input logic [31:0] rd);
    bit mis;
    bit done_ok;
    int c;
    int last;
    mis          = mdl_misaligned(f3, a);
    mem_op_valid = 1'b1;
    mem_we       = we;
    funct3       = f3;
    addr         = a;
    wdata        = wd;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    @(negedge clk);
    chk_eq("stall_issue", 32'(stall), 32'(!mis));
    chk_eq("req_issue", 32'(dmem_req), 32'd0);

    if (mis) begin
      @(posedge clk); #1;
      mem_op_valid = 1'b0;
      @(negedge clk);
      chk_eq("misalign_exc", 32'(misalign_exc), 32'd1);
      chk_eq("misalign_exc_addr", exc_addr, a);
      chk_eq("misalign_req", 32'(dmem_req), 32'd0);
      chk_eq("misalign_stall", 32'(stall), 32'd0);
      chk_eq("misalign_ld_funct3", 32'(ld_funct3), 32'(last_f3));
      @(posedge clk); #1;
      @(negedge clk);
      chk_eq("misalign_pulse", 32'(misalign_exc), 32'd0);
      chk_eq("misalign_noreq", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end

    last_f3  = f3;
    last_off = a[1:0];
    c        = we ? g : g + rv;
    done_ok  = (c <= TIMEOUT - 1);
    last     = done_ok ? c : TIMEOUT - 1;

    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      dmem_gnt    = (j == g);
      dmem_rvalid = !we && (j == g + rv);
      dmem_rdata  = (j == g + rv) ? rd : $urandom;
      @(negedge clk);
      chk_eq("stall_busy", 32'(stall), 32'd1);
      chk_eq("req_phase", 32'(dmem_req), 32'(j <= g));
      if (j == 0) begin
        chk_eq("dmem_we", 32'(dmem_we), 32'(we));
        chk_eq("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk_eq("dmem_be", 32'(dmem_be), 32'(mdl_be(f3, a)));
        if (we) chk_eq("dmem_wdata", dmem_wdata, mdl_wdata(f3, wd));
      end
    end

    @(posedge clk); #1;
    mem_op_valid = 1'b0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    @(negedge clk);
    chk_eq("stall_end", 32'(stall), 32'd0);
    chk_eq("req_end", 32'(dmem_req), 32'd0);
    chk_eq("ld_funct3", 32'(ld_funct3), 32'(f3));
    chk_eq("ld_offset", 32'(ld_offset), 32'(a[1:0]));
    if (done_ok) begin
      chk_eq("ld_valid_done", 32'(ld_valid), 32'(!we));
      chk_eq("bus_err_done", 32'(bus_err), 32'd0);
      if (!we) chk_eq("ld_data", ld_data, rd);
    end else begin
      chk_eq("bus_err", 32'(bus_err), 32'd1);
      chk_eq("bus_err_addr", exc_addr, a);
      chk_eq("ld_valid_timeout", 32'(ld_valid), 32'd0);
    end

    // Stale handshake noise while idle must be ignored.
    @(posedge clk); #1;
    dmem_gnt    = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(negedge clk);
    chk_eq("ld_valid_pulse", 32'(ld_valid), 32'd0);
    chk_eq("bus_err_pulse", 32'(bus_err), 32'd0);
    chk_eq("req_idle", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk_eq("ld_valid_stale", 32'(ld_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          g;
    int          rv;
    n_tests      = 0;
    n_fail       = 0;
    last_f3      = 3'b000;
    last_off     = 2'b00;
    rst          = 1'b1;
    mem_op_valid = 1'b0;
    mem_we       = 1'b0;
    funct3       = 3'b000;
    addr         = 32'h0;
    wdata        = 32'h0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_stall", 32'(stall), 32'd0);
    chk_eq("rst_req", 32'(dmem_req), 32'd0);
    chk_eq("rst_we", 32'(dmem_we), 32'd0);
    chk_eq("rst_be", 32'(dmem_be), 32'd0);
    chk_eq("rst_addr", dmem_addr, 32'd0);
    chk_eq("rst_wdata", dmem_wdata, 32'd0);
    chk_eq("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk_eq("rst_ld_data", ld_data, 32'd0);
    chk_eq("rst_ld_funct3", 32'(ld_funct3), 32'd0);
    chk_eq("rst_ld_offset", 32'(ld_offset), 32'd0);
    chk_eq("rst_misalign", 32'(misalign_exc), 32'd0);
    chk_eq("rst_bus_err", 32'(bus_err), 32'd0);
    chk_eq("rst_exc_addr", exc_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 2, 0, 32'h0);
    do_op(1'b0, 3'b010, 32'h0000_2000, 32'h0, 0, 3, 32'h1234_5678);
    do_op(1'b0, 3'b001, 32'h0000_2003, 32'h0, 0, 0, 32'h0);
    do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 1, 1, 32'hCAFE_F00D);
    do_op(1'b0, 3'b010, 32'h0000_2404, 32'h0, 1, 0, 32'h0BAD_BEEF);
    do_op(1'b0, 3'b010, 32'h0000_2800, 32'h0, 0, 40, 32'h0);
    do_op(1'b1, 3'b010, 32'h0000_2C00, 32'h1111_2222, 30, 0, 32'h0);
    do_op(1'b0, 3'b100, 32'h0000_2C01, 32'h0, 15, 0, 32'h5A5A_A5A5);
    do_op(1'b0, 3'b000, 32'h0000_2C02, 32'h0, 15, 1, 32'h0);
    do_op(1'b1, 3'b001, 32'h0000_3002, 32'h0000_BEEF, 0, 0, 32'h0);
    do_op(1'b1, 3'b011, 32'h0000_3000, 32'h0, 0, 0, 32'h0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    mem_op_valid = 1'b1;
    mem_we       = 1'b0;
    funct3       = 3'b010;
    addr         = 32'h0000_4000;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk_eq("wait_r_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst          = 1'b0;
    mem_op_valid = 1'b0;
    dmem_rvalid  = 1'b1;
    dmem_rdata   = 32'hDEAD_0001;
    last_f3      = 3'b000;
    last_off     = 2'b00;
    @(negedge clk);
    chk_eq("rst_mid_req", 32'(dmem_req), 32'd0);
    chk_eq("rst_mid_ld_valid", 32'(ld_valid), 32'd0);
    chk_eq("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk_eq("rst_mid_drop", 32'(ld_valid), 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 3'b010, 32'h0000_3000, 32'h0102_0304, 1, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 9))
        0:       g = 20;
        1:       g = $urandom_range(12, 16);
        default: g = $urandom_range(0, 4);
      endcase
      case ($urandom_range(0, 9))
        0:       rv = 20;
        1:       rv = $urandom_range(0, 16);
        default: rv = $urandom_range(0, 4);
      endcase
      do_op(we, f3, a, $urandom, g, rv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
